// File: rtl/pc_driver.sv
// pc_driver: turns STEP/FWD/BACK/HALT requests into PC inc/add/sub strobes.
// Optional macro PC_DRV_WRAP_CHECK_EN enables branch range checks against pc_in.
module pc_driver (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_arg,
   input  logic [15:0] pc_in,
   output logic        inc,
   output logic        add,
   output logic        sub,
   output logic [15:0] offset,
   output logic        busy,
   output logic        halted,
   output logic        err
);

   typedef enum logic [1:0] {
      OP_STEP = 2'b00,
      OP_FWD  = 2'b01,
      OP_BACK = 2'b10,
      OP_HALT = 2'b11
   } op_e;

   op_e         op_q, op_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] off_q, off_d;
   logic        halted_q, halted_d;
   logic        err_q, err_d;
   logic        inc_q, inc_d;
   logic        add_q, add_d;
   logic        sub_q, sub_d;
   logic [15:0] offset_q, offset_d;
   logic        accept;
   logic        reject;

`ifdef PC_DRV_WRAP_CHECK_EN
   logic [16:0] fwd_sum;

   assign fwd_sum   = {1'b0, pc_in} + {1'b0, req_arg};
   assign reject    = ((op_e'(req_op) == OP_FWD) && (fwd_sum > 17'h0FFFF))
                   || ((op_e'(req_op) == OP_BACK) && (req_arg > pc_in));
   // Issue only when idle so pc_in already reflects every earlier pulse.
   assign req_ready = (cnt_q == 16'd0) && !halted_q;
`else
   logic unused_pc;

   assign unused_pc = ^pc_in;
   assign reject    = 1'b0;
   assign req_ready = (cnt_q <= 16'd1) && !halted_q;
`endif

   assign accept = req_valid && req_ready;
   assign busy   = (cnt_q != 16'd0);

   always_comb begin
      op_d     = op_q;
      off_d    = off_q;
      halted_d = halted_q;
      err_d    = 1'b0;
      cnt_d    = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
      if (accept) begin
         unique case (op_e'(req_op))
            OP_STEP: begin
               op_d  = OP_STEP;
               cnt_d = req_arg;
            end
            OP_FWD, OP_BACK: begin
               op_d  = op_e'(req_op);
               off_d = req_arg;
               cnt_d = reject ? 16'd0 : 16'd1;
               err_d = reject;
            end
            OP_HALT: begin
               cnt_d    = 16'd0;
               halted_d = 1'b1;
            end
         endcase
      end
      inc_d    = (op_d == OP_STEP) && (cnt_d != 16'd0);
      add_d    = (op_d == OP_FWD)  && (cnt_d != 16'd0);
      sub_d    = (op_d == OP_BACK) && (cnt_d != 16'd0);
      offset_d = (add_d || sub_d) ? off_d : 16'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q     <= OP_STEP;
         cnt_q    <= 16'd0;
         off_q    <= 16'd0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
         inc_q    <= 1'b0;
         add_q    <= 1'b0;
         sub_q    <= 1'b0;
         offset_q <= 16'd0;
      end else begin
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         off_q    <= off_d;
         halted_q <= halted_d;
         err_q    <= err_d;
         inc_q    <= inc_d;
         add_q    <= add_d;
         sub_q    <= sub_d;
         offset_q <= offset_d;
      end
   end

   assign inc    = inc_q;
   assign add    = add_q;
   assign sub    = sub_q;
   assign offset = offset_q;
   assign halted = halted_q;
   assign err    = err_q;

endmodule

// File: doc/pc_driver.md
PC_DRIVER -- requirements
Module: pc_driver

Interface
REQ-001 The module SHALL have the following ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on any rising edge where req_valid && req_ready.
- req_op  in  2  00 STEP, 01 FWD, 10 BACK, 11 HALT.
- req_arg  in  16  STEP: pulse count; FWD/BACK: offset; HALT: ignored.
- pc_in  in  16  current PC register contents (read only when PC_DRV_WRAP_CHECK_EN is defined).
- inc, add, sub  out  1 each  PC command strobes.
- offset  out  16  PC offset operand.
- busy  out  1  command pulses outstanding.
- halted  out  1  HALT has been accepted.
- err  out  1  one-cycle pulse on a rejected branch.

REQ-002 All outputs SHALL be driven from registers, except req_ready and busy.

Function
REQ-003 Internal state SHALL consist of op[1:0], cnt[15:0] (pulses remaining, including the current cycle), off[15:0], halted, and err.
REQ-004 The strobes SHALL decode as follows, so that at most one strobe is high in any cycle:
- inc = (op==STEP) && cnt!=0
- add = (op==FWD) && cnt!=0
- sub = (op==BACK) && cnt!=0
REQ-005 offset SHALL equal off whenever add or sub is high, and 0 otherwise.
REQ-006 busy SHALL equal (cnt!=0).
REQ-007 req_ready SHALL be 0 when halted.
REQ-008 When not halted, req_ready SHALL be (cnt<=1); the next request may be accepted during the last pulse cycle, giving gap-free back-to-back commands.
REQ-009 Acceptance of STEP with arg N SHALL behave as follows:
- N != 0: op=STEP, cnt=N; inc is high for exactly N consecutive cycles starting the cycle after acceptance.
- N == 0: cnt=0; no pulse is issued.
REQ-010 Acceptance of FWD or BACK SHALL set op, cnt=1 and off=req_arg, giving exactly one add or sub pulse in the cycle after acceptance.
REQ-011 Acceptance of HALT SHALL set cnt=0 and halted=1 at that edge; all further requests are blocked until reset.
REQ-012 HALT accepted during the last pulse of a STEP SHALL NOT truncate that pulse.
REQ-013 With no acceptance in a cycle, a nonzero cnt SHALL decrement by 1; a zero cnt holds.
REQ-014 cnt SHALL never wrap below 0.
REQ-015 A STEP with N=0xFFFF SHALL produce exactly 65535 inc pulses.
REQ-016 req_op, req_arg and pc_in SHALL be sampled only on an accepting edge; changes while req_ready=0 SHALL have no effect.

Reset
REQ-017 Asserting reset SHALL immediately clear cnt, op, off, halted and err to 0, forcing inc=add=sub=0, offset=0, busy=0 and err=0, at any time including mid-STEP.
REQ-018 req_ready SHALL read 1 while reset is asserted and after reset is released.
REQ-019 The first acceptance SHALL be possible on the first rising edge after reset is deasserted.

Configuration
REQ-020 The module SHALL support a single compile-time macro, PC_DRV_WRAP_CHECK_EN.
REQ-021 With PC_DRV_WRAP_CHECK_EN defined:
- Branch range check, performed against pc_in at the accepting edge:
  - FWD is rejected when pc_in + req_arg > 0xFFFF (17-bit compare).
  - BACK is rejected when req_arg > pc_in.
- A rejected request is consumed but issues no pulse (cnt=0), and err is high for exactly the following cycle.
- req_ready is (cnt==0) && !halted, so pc_in always reflects every issued pulse.
REQ-022 Without PC_DRV_WRAP_CHECK_EN:
- pc_in is ignored.
- err is constant 0.
- PC arithmetic wraps modulo 2^16 downstream.
- req_ready follows REQ-007/REQ-008.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- STEP arg=3 accepted at edge k -> inc=1 in cycles k+1..k+3 and 0 at k+4; busy mirrors inc; add=sub=0 throughout.
- FWD arg=0x0010 immediately followed by BACK arg=0x0004 (macro off) -> add with offset=0x0010 in cycle k+1, then sub with offset=0x0004 in cycle k+2, with no gap.
- STEP arg=0 -> no strobe; req_ready stays 1.
- Reset asserted in the 2nd cycle of STEP arg=5 -> strobes and busy drop without waiting for clk; after release, STEP arg=1 yields a single inc.
- HALT, then FWD held valid for 10 cycles -> halted=1, req_ready=0, no strobe; a reset pulse clears halted.
- Macro on, pc_in=0xFFF0, FWD arg=0x0020 -> no add, err=1 for one cycle; pc_in=0x0003, BACK arg=0x0003 -> sub with offset=0x0003 and err=0.
